// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch / mult-div hazard detection and stall control
//
// Sits beside the ID stage. Detects hazards that forwarding cannot resolve and
// freezes PC and IF/ID while injecting a bubble into ID/EX.
//
// Ports:
//   Clk, Reset                 pipeline clock, synchronous active-high reset
//   IFIDRs, IFIDRt             source registers of the instruction in ID
//   IFIDUsesRt                 ID instruction reads Rt
//   IFIDBranch                 ID instruction is beq/bne (compared in ID)
//   IFIDMultDiv                ID instruction is mult/multu/div/divu
//   IFIDReadHiLo               ID instruction is mfhi/mflo
//   IDEXMemRead, IDEXRegWrite  EX instruction is a load / writes a register
//   IDEXRt, IDEXRd             EX load destination / ALU destination
//   EXMEMMemRead, EXMEMRd      MEM instruction is a load / its destination
//   PCWrite, IFIDWrite         0 = hold PC / hold IF/ID
//   IDEXFlush                  1 = bubble into ID/EX
//   MDStart                    one-cycle start pulse to the mult/div unit
//   MDBusy                     mult/div result not yet available
//   StallCount                 stall-cycle counter (only with HAZARD_STALL_CNT_EN)
//
// Optional feature macro: HAZARD_STALL_CNT_EN

module hazard_stall_unit #(
  parameter int MD_LATENCY = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IFIDRs,
  input  logic [4:0]  IFIDRt,
  input  logic        IFIDUsesRt,
  input  logic        IFIDBranch,
  input  logic        IFIDMultDiv,
  input  logic        IFIDReadHiLo,
  input  logic        IDEXMemRead,
  input  logic        IDEXRegWrite,
  input  logic [4:0]  IDEXRt,
  input  logic [4:0]  IDEXRd,
  input  logic        EXMEMMemRead,
  input  logic [4:0]  EXMEMRd,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXFlush,
  output logic        MDStart,
`ifdef HAZARD_STALL_CNT_EN
  output logic        MDBusy,
  output logic [31:0] StallCount
`else
  output logic        MDBusy
`endif
);

  localparam int CW = $clog2(MD_LATENCY + 1);

  logic [CW-1:0] md_cnt;
  logic          load_use;
  logic          branch_ex;
  logic          branch_mem;
  logic          md_haz;
  logic          stall;

  assign MDBusy = (md_cnt != '0);

  // Register 0 is hard-wired, so a zero destination never creates a dependence.
  always_comb begin
    load_use   = IDEXMemRead && (IDEXRt != 5'd0) &&
                 ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));
    branch_ex  = IFIDBranch && IDEXRegWrite && (IDEXRd != 5'd0) &&
                 ((IDEXRd == IFIDRs) || (IDEXRd == IFIDRt));
    branch_mem = IFIDBranch && EXMEMMemRead && (EXMEMRd != 5'd0) &&
                 ((EXMEMRd == IFIDRs) || (EXMEMRd == IFIDRt));
    // mfhi/mflo wait for the result; a second mult/div waits for the unit.
    md_haz     = (IFIDReadHiLo || IFIDMultDiv) && MDBusy;
    stall      = load_use || branch_ex || branch_mem || md_haz;

    PCWrite    = !stall;
    IFIDWrite  = !stall;
    IDEXFlush  = stall;
    // MDHaz blocks a start while busy, so the counter is never reloaded mid-run.
    MDStart    = IFIDMultDiv && !stall;
  end

  // Busy counter doubles as the IDLE/BUSY state: zero is IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      md_cnt <= '0;
    end else if (MDStart) begin
      md_cnt <= CW'(MD_LATENCY);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Free-running stall counter; wraps naturally at 32 bits.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= 32'd0;
    end else if (stall) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
//
// Driver applies one input vector per cycle, evaluates a reference model and
// queues the expected outputs; a monitor on the falling edge pops and compares.
// Optional feature macro: HAZARD_STALL_CNT_EN

module tb_hazard_stall_unit;

  localparam int LAT = 4;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       md;
    logic       hilo;
    logic       idex_mr;
    logic       idex_rw;
    logic [4:0] idex_rt;
    logic [4:0] idex_rd;
    logic       exmem_mr;
    logic [4:0] exmem_rd;
  } in_t;

  typedef struct {
    int          cyc;
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] sc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  IFIDRs, IFIDRt;
  logic        IFIDUsesRt, IFIDBranch, IFIDMultDiv, IFIDReadHiLo;
  logic        IDEXMemRead, IDEXRegWrite;
  logic [4:0]  IDEXRt, IDEXRd;
  logic        EXMEMMemRead;
  logic [4:0]  EXMEMRd;
  logic        PCWrite, IFIDWrite, IDEXFlush, MDStart, MDBusy;
  logic [31:0] StallCount;

  hazard_stall_unit #(.MD_LATENCY(LAT)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .IFIDRs       (IFIDRs),
    .IFIDRt       (IFIDRt),
    .IFIDUsesRt   (IFIDUsesRt),
    .IFIDBranch   (IFIDBranch),
    .IFIDMultDiv  (IFIDMultDiv),
    .IFIDReadHiLo (IFIDReadHiLo),
    .IDEXMemRead  (IDEXMemRead),
    .IDEXRegWrite (IDEXRegWrite),
    .IDEXRt       (IDEXRt),
    .IDEXRd       (IDEXRd),
    .EXMEMMemRead (EXMEMMemRead),
    .EXMEMRd      (EXMEMRd),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IDEXFlush    (IDEXFlush),
    .MDStart      (MDStart),
`ifdef HAZARD_STALL_CNT_EN
    .MDBusy       (MDBusy),
    .StallCount   (StallCount)
`else
    .MDBusy       (MDBusy)
`endif
  );

`ifndef HAZARD_STALL_CNT_EN
  assign StallCount = 32'd0;
`endif

  always #5 Clk = ~Clk;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  in_t         nx;
  int          cyc = 0;
  int          last_start = -1000;
  logic [31:0] m_sc = 32'd0;
  int          starts_seen = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, req);
    end
  endtask

  task automatic clear_nx();
    nx = '{default: '0};
  endtask

  // One pipeline cycle: apply nx, evaluate the model, queue expectation.
  task automatic step(input bit check);
    exp_t e;
    bit   busy, lu, bex, bmem, mdh, stall;
    @(posedge Clk);
    #1;
    cyc++;
    Reset = nx.rst; IFIDRs = nx.rs; IFIDRt = nx.rt; IFIDUsesRt = nx.uses_rt;
    IFIDBranch = nx.br; IFIDMultDiv = nx.md; IFIDReadHiLo = nx.hilo;
    IDEXMemRead = nx.idex_mr; IDEXRegWrite = nx.idex_rw; IDEXRt = nx.idex_rt;
    IDEXRd = nx.idex_rd; EXMEMMemRead = nx.exmem_mr; EXMEMRd = nx.exmem_rd;

    // Result busy for the LAT cycles following the accepted start.
    busy  = (cyc - last_start >= 1) && (cyc - last_start <= LAT);
    lu    = nx.idex_mr && nx.idex_rt != 0 &&
            (nx.idex_rt == nx.rs || (nx.uses_rt && nx.idex_rt == nx.rt));
    bex   = nx.br && nx.idex_rw && nx.idex_rd != 0 &&
            (nx.idex_rd == nx.rs || nx.idex_rd == nx.rt);
    bmem  = nx.br && nx.exmem_mr && nx.exmem_rd != 0 &&
            (nx.exmem_rd == nx.rs || nx.exmem_rd == nx.rt);
    mdh   = (nx.md || nx.hilo) && busy;
    stall = lu || bex || bmem || mdh;

    e.cyc = cyc; e.pcw = !stall; e.ifw = !stall; e.flush = stall;
    e.start = nx.md && !stall; e.busy = busy; e.sc = m_sc;
    if (check) sb.push_back(e);

    if (e.start) last_start = cyc;
    if (nx.rst) begin
      last_start = -1000;
      m_sc = 32'd0;
    end else if (stall) begin
      m_sc = m_sc + 32'd1;
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("PCWrite",   e.cyc, {31'd0, PCWrite},   {31'd0, e.pcw});
      chk("IFIDWrite", e.cyc, {31'd0, IFIDWrite}, {31'd0, e.ifw});
      chk("IDEXFlush", e.cyc, {31'd0, IDEXFlush}, {31'd0, e.flush});
      chk("MDStart",   e.cyc, {31'd0, MDStart},   {31'd0, e.start});
      chk("MDBusy",    e.cyc, {31'd0, MDBusy},    {31'd0, e.busy});
`ifdef HAZARD_STALL_CNT_EN
      chk("StallCount", e.cyc, StallCount, e.sc);
`endif
      if (MDStart === 1'b1) starts_seen++;
    end
  end

  initial begin
    int exp_starts;
    exp_starts = 0;
    clear_nx();
    nx.rst = 1'b1;
    step(1'b0);                 // counter undefined until the first reset edge
    step(1'b1);
    clear_nx();
    step(1'b1);                 // reset state with all inputs zero

    // Load-use on Rs, then the bubble clears it; Rt=0 never hazards.
    nx.idex_mr = 1; nx.idex_rt = 5; nx.rs = 5; step(1'b1);
    clear_nx(); nx.rs = 5; step(1'b1);
    nx.idex_mr = 1; nx.idex_rt = 0; nx.rs = 0; step(1'b1);
    clear_nx(); nx.idex_mr = 1; nx.idex_rt = 9; nx.rt = 9; nx.uses_rt = 1; step(1'b1);
    nx.uses_rt = 0; step(1'b1);

    // Branch after ALU writer: one stall.
    clear_nx(); nx.br = 1; nx.rs = 3; nx.idex_rw = 1; nx.idex_rd = 3; step(1'b1);
    clear_nx(); nx.br = 1; nx.rs = 3; step(1'b1);

    // Branch after load: LoadUse then BranchMEM.
    clear_nx(); nx.br = 1; nx.rs = 7; nx.uses_rt = 1; nx.idex_mr = 1; nx.idex_rt = 7; step(1'b1);
    clear_nx(); nx.br = 1; nx.rs = 7; nx.exmem_mr = 1; nx.exmem_rd = 7; step(1'b1);
    clear_nx(); nx.br = 1; nx.rs = 7; step(1'b1);

    // mult then mflo: stalls for LAT cycles, proceeds after.
    clear_nx(); nx.md = 1; step(1'b1); exp_starts++;
    clear_nx(); nx.hilo = 1;
    for (int i = 0; i < LAT + 1; i++) step(1'b1);

    // Back-to-back mults: second waits for the unit.
    clear_nx(); nx.md = 1;
    for (int i = 0; i < 2 * LAT + 2; i++) step(1'b1);
    exp_starts += 2;

    // Reset while busy releases a pending mfhi.
    clear_nx(); for (int i = 0; i < LAT; i++) step(1'b1);
    nx.md = 1; step(1'b1); exp_starts++;
    clear_nx(); nx.hilo = 1; step(1'b1); step(1'b1);
    nx.rst = 1; step(1'b1);
    nx.rst = 0; step(1'b1); step(1'b1);

    // Settle, then confirm the pulse count of the directed section.
    clear_nx(); for (int i = 0; i < LAT + 2; i++) step(1'b1);
    repeat (2) @(negedge Clk);
    chk("mdstart_pulses", cyc, starts_seen, exp_starts);

    // Randomized traffic over a small register set to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      nx.rst      = ($urandom_range(0, 79) == 0);
      nx.rs       = 5'($urandom_range(0, 3));
      nx.rt       = 5'($urandom_range(0, 3));
      nx.uses_rt  = 1'($urandom_range(0, 1));
      nx.br       = ($urandom_range(0, 3) == 0);
      nx.md       = ($urandom_range(0, 7) == 0);
      nx.hilo     = ($urandom_range(0, 5) == 0);
      nx.idex_mr  = ($urandom_range(0, 3) == 0);
      nx.idex_rw  = 1'($urandom_range(0, 1));
      nx.idex_rt  = 5'($urandom_range(0, 3));
      nx.idex_rd  = 5'($urandom_range(0, 3));
      nx.exmem_mr = ($urandom_range(0, 3) == 0);
      nx.exmem_rd = 5'($urandom_range(0, 3));
      step(1'b1);
    end

    clear_nx();
    step(1'b1);
    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", cyc, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Hazard-detection and stall controller for the 5-stage MIPS pipeline; the counterpart to the forwarding logic. Forwarding resolves hazards by routing EX/MEM and MEM/WB results back to EX. This block handles the hazards forwarding cannot cover:
- load-use,
- ID-stage branch operand dependences,
- the multi-cycle mult/div unit's HI/LO results.

When a hazard exists, the block freezes PC and IF/ID and injects a bubble into ID/EX. It sits beside the ID stage and tracks mult/div occupancy with an internal busy counter.

## Interface
- MD_LATENCY, 32: mult/div cycles from start until HI/LO are valid (1..255).
- Clk  input  1  pipeline clock, all state on rising edge.
- Reset  input  1  synchronous, active-high.
- IFIDRs, IFIDRt  input  5  source registers of instruction in ID.
- IFIDUsesRt  input  1  ID instruction reads Rt (R-type, store, beq/bne).
- IFIDBranch  input  1  ID instruction is beq/bne (compared in ID).
- IFIDMultDiv  input  1  ID instruction is mult/multu/div/divu.
- IFIDReadHiLo  input  1  ID instruction is mfhi/mflo.
- IDEXMemRead, IDEXRegWrite  input  1  EX-stage instruction is a load / writes a register.
- IDEXRt, IDEXRd  input  5  EX-stage load destination / ALU destination.
- EXMEMMemRead  input  1  MEM-stage instruction is a load.
- EXMEMRd  input  5  MEM-stage destination.
- PCWrite, IFIDWrite  output  1  0 = hold PC / hold IF/ID.
- IDEXFlush  output  1  1 = zero ID/EX control bits (bubble).
- MDStart  output  1  one-cycle start pulse to mult/div unit.
- MDBusy  output  1  mult/div in progress.
- StallCount  output  32  stall-cycle counter (only with HAZARD_STALL_CNT_EN).

## Operation
- Register 0 never causes a hazard; every match below requires the compared register to be nonzero.
- LoadUse = IDEXMemRead and either IDEXRt == IFIDRs, or IFIDUsesRt and IDEXRt == IFIDRt.
- BranchEX = IFIDBranch and IDEXRegWrite and IDEXRd matches IFIDRs or IFIDRt.
- BranchMEM = IFIDBranch and EXMEMMemRead and EXMEMRd matches IFIDRs or IFIDRt.
- MDHaz = (IFIDReadHiLo or IFIDMultDiv) and MDBusy.
  - mfhi/mflo wait for the result.
  - A second mult/div waits on the structural hazard.
- Stall = LoadUse | BranchEX | BranchMEM | MDHaz.
- Stall drives PCWrite=0, IFIDWrite=0, IDEXFlush=1. Otherwise the outputs are 1, 1, 0.
- MDStart = IFIDMultDiv & ~Stall. It is combinational and occurs exactly once per accepted mult/div.
- Busy counter behaviour (width ceil(log2(MD_LATENCY+1))):
  - Loads MD_LATENCY on a cycle where MDStart=1.
  - Otherwise decrements while nonzero.
  - MDBusy = (counter != 0).
- State machine, implicit in the counter:
  - IDLE (0) → BUSY on MDStart.
  - BUSY → IDLE after MD_LATENCY cycles.
  - MDStart cannot occur in BUSY because MDHaz blocks it.

## Timing
- Reset values:
  - Counter = 0, MDBusy = 0, StallCount = 0.
  - With all other inputs 0: PCWrite=1, IFIDWrite=1, IDEXFlush=0, MDStart=0.
- Stall outputs are combinational, same cycle as the causing inputs; zero latency.
- Load-use stalls 1 cycle. The bubble moves the load to MEM, and forwarding covers the rest.
- Branch after ALU writer: 1 stall cycle. Branch after a load: 2 cycles (BranchEX-equivalent via LoadUse, then BranchMEM).
- Mult/div cycle timing:
  - MDStart in cycle N → MDBusy high in cycles N+1..N+MD_LATENCY.
  - mfhi in ID during those cycles stalls; it proceeds in cycle N+MD_LATENCY+1.
- Simultaneous hazards: the outputs are identical, since stall is a single OR.
- Reset asserted mid-operation: counter clears on that edge, and MDBusy=0 in the next cycle.

## Configuration
- HAZARD_STALL_CNT_EN defined:
  - 32-bit StallCount increments each cycle Stall=1.
  - It wraps 0xFFFFFFFF→0 and clears on Reset.
- Undefined: StallCount port is absent and no counter logic is built.

## Test plan
- lw $5 in EX (IDEXMemRead=1, IDEXRt=5), add with IFIDRs=5 in ID → PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly 1 cycle; IDEXRt=0 gives no stall.
- beq with IFIDRs=3, IDEXRegWrite=1, IDEXRd=3 → 1-cycle stall; next cycle EXMEMMemRead=0 → no stall.
- MD_LATENCY=4:
  - mult in ID at cycle 10 → MDStart=1 in cycle 10, MDBusy high in cycles 11–14.
  - mflo arriving at cycle 11 stalls cycles 11–14 and proceeds at cycle 15.
- Two mult back-to-back → second stalls until MDBusy falls; exactly one MDStart per mult.
- Reset during MDBusy (counter=3) → MDBusy=0 next cycle, and a pending mfhi is released.
- With HAZARD_STALL_CNT_EN: 2-cycle load→branch sequence → StallCount increments by 2; preloaded 0xFFFFFFFF wraps to 0.
